// File: rtl/uart_rx_capture.sv
// uart_rx_capture: 8N1 UART receiver with 16x oversampling, byte FIFO and
// sticky status flags (framing error, overrun, end-of-test character).
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | line idle, waiting for a falling edge on the synchronized line
// S_START | inside start bit, confirm it is still low at mid-bit
// S_DATA  | sampling 8 data bits at mid-bit, LSB first
// S_STOP  | sampling the stop bit at mid-bit
// S_BREAK | stop bit was low; wait for the line to return high
module uart_rx_capture #(
    parameter int unsigned DIV        = 22,
    parameter int unsigned OVS        = 16,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [7:0]  EOT_CHAR   = 8'h04
) (
    input  logic                          CLK,
    input  logic                          RSTN,
    input  logic                          RXD,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          eot,
    input  logic                          flag_clr
);

    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned TW = $clog2(OVS);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [TW-1:0] T_HALF   = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] T_FULL   = TW'(OVS - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync2_q, rxs_prev_q;
    logic [DW-1:0]   div_q, div_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic            eot_q, eot_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic rxs, fall, tick, sample_mid, sample_bit;
    logic push, frame_set, pop, accept;

    assign rxs        = sync2_q;
    assign fall       = rxs_prev_q & ~rxs;
    assign tick       = (state_q != S_IDLE) && (div_q == DIV_LAST);
    assign sample_mid = tick && (tcnt_q == T_HALF);
    assign sample_bit = tick && (tcnt_q == T_FULL);

    // State register plus all datapath flops; everything returns to idle on reset.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            rxs_prev_q  <= 1'b1;
            div_q       <= '0;
            tcnt_q      <= '0;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            eot_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= RXD;
            sync2_q     <= sync1_q;
            rxs_prev_q  <= sync2_q;
            div_q       <= div_d;
            tcnt_q      <= tcnt_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            eot_q       <= eot_d;
        end
    end

    // Byte storage needs no reset: reads are masked while the FIFO is empty.
    always_ff @(posedge CLK) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= shreg_q;
        end
    end

    // Next-state logic for the deframing FSM.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (fall) state_d = S_START;
            S_START: if (sample_mid) state_d = rxs ? S_IDLE : S_DATA;
            S_DATA:  if (sample_bit && (bitcnt_q == 3'd7)) state_d = S_STOP;
            S_STOP:  if (sample_bit) state_d = rxs ? S_IDLE : S_BREAK;
            S_BREAK: if (rxs) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Oversample divider, per-state tick count, bit count and shift register.
    always_comb begin
        div_d    = div_q;
        tcnt_d   = tcnt_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;

        // Divider idles at 0, which also aligns it on the start-detect cycle.
        if (state_q == S_IDLE || tick) begin
            div_d = '0;
        end else begin
            div_d = div_q + DW'(1);
        end

        if (state_d != state_q) begin
            tcnt_d = '0;
        end else if (tick) begin
            tcnt_d = (tcnt_q == T_FULL) ? '0 : tcnt_q + TW'(1);
        end

        if (state_q == S_START && state_d == S_DATA) begin
            bitcnt_d = '0;
        end else if (state_q == S_DATA && sample_bit) begin
            bitcnt_d = bitcnt_q + 3'd1;
            shreg_d  = {rxs, shreg_q[7:1]};
        end
    end

    // Output decode: push/frame error events, FIFO bookkeeping and sticky flags.
    always_comb begin
        push      = (state_q == S_STOP) && sample_bit && rxs;
        frame_set = (state_q == S_STOP) && sample_bit && !rxs;
        pop       = (cnt_q != '0) && rx_ready;
        // A full FIFO still takes the byte when the head leaves in the same cycle.
        accept    = push && ((cnt_q < DEPTH_C) || pop);

        wr_ptr_d = wr_ptr_q + AW'(accept);
        rd_ptr_d = rd_ptr_q + AW'(pop);

        cnt_d = cnt_q;
        unique case ({accept, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        // Set has priority over clear so no event is lost to a coincident clear.
        frame_err_d = frame_set                      | (frame_err_q & ~flag_clr);
        overrun_d   = (push && !accept)              | (overrun_q   & ~flag_clr);
        eot_d       = (push && shreg_q == EOT_CHAR)  | (eot_q       & ~flag_clr);
    end

    assign rx_valid   = (cnt_q != '0);
    assign rx_data    = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign fifo_count = cnt_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign eot        = eot_q;

endmodule

// File: tb/tb_uart_rx_capture.sv
// Testbench for uart_rx_capture: directed scenarios plus randomized byte
// streams, checked against a queue-based model of the received byte stream.
module tb_uart_rx_capture;

    localparam int DIV   = 2;
    localparam int OVS   = 16;
    localparam int DEPTH = 16;
    localparam int BIT   = DIV * OVS;

    logic       CLK = 1'b0;
    logic       RSTN = 1'b0;
    logic       RXD = 1'b1;
    logic       rx_ready = 1'b0;
    logic       flag_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [4:0] fifo_count;
    logic       frame_err, overrun, eot;

    int checks = 0;
    int errors = 0;

    byte unsigned mq[$];
    bit m_fe = 1'b0, m_ov = 1'b0, m_eot = 1'b0;

    always #5 CLK = ~CLK;

    uart_rx_capture #(
        .DIV(DIV), .OVS(OVS), .FIFO_DEPTH(DEPTH), .EOT_CHAR(8'h04)
    ) dut (
        .CLK(CLK), .RSTN(RSTN), .RXD(RXD),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .fifo_count(fifo_count), .frame_err(frame_err), .overrun(overrun),
        .eot(eot), .flag_clr(flag_clr)
    );

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, ".frame_err"}, frame_err, m_fe);
        chk({tag, ".overrun"}, overrun, m_ov);
        chk({tag, ".eot"}, eot, m_eot);
    endtask

    task automatic chk_head(input string tag);
        chk({tag, ".count"}, fifo_count, mq.size());
        chk({tag, ".valid"}, rx_valid, (mq.size() > 0));
        if (mq.size() > 0) chk({tag, ".data"}, rx_data, mq[0]);
    endtask

    // One 8N1 character; a bad stop holds the line low for two bit times.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        RXD = 1'b0;
        repeat (BIT) cyc();
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            repeat (BIT) cyc();
        end
        if (stop_ok) begin
            RXD = 1'b1;
            repeat (BIT) cyc();
        end else begin
            RXD = 1'b0;
            repeat (2 * BIT) cyc();
            RXD = 1'b1;
            repeat (BIT) cyc();
        end
        if (stop_ok) begin
            if (mq.size() < DEPTH) mq.push_back(b);
            else m_ov = 1'b1;
            if (b == 8'h04) m_eot = 1'b1;
        end else begin
            m_fe = 1'b1;
        end
    endtask

    task automatic drain(input string tag);
        while (mq.size() > 0) begin
            chk({tag, ".pop_valid"}, rx_valid, 1'b1);
            chk({tag, ".pop_data"}, rx_data, mq[0]);
            rx_ready = 1'b1;
            cyc();
            rx_ready = 1'b0;
            void'(mq.pop_front());
        end
        chk({tag, ".empty_valid"}, rx_valid, 1'b0);
        chk({tag, ".empty_count"}, fifo_count, 0);
    endtask

    task automatic clear_flags();
        flag_clr = 1'b1;
        cyc();
        flag_clr = 1'b0;
        m_fe = 1'b0;
        m_ov = 1'b0;
        m_eot = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".rx_data"}, rx_data, 0);
        chk({tag, ".rx_valid"}, rx_valid, 0);
        chk({tag, ".fifo_count"}, fifo_count, 0);
        chk({tag, ".frame_err"}, frame_err, 0);
        chk({tag, ".overrun"}, overrun, 0);
        chk({tag, ".eot"}, eot, 0);
    endtask

    initial begin
        logic [7:0] f0;
        int n;
        logic [7:0] b;
        bit ok;

        // Reset state
        repeat (3) cyc();
        chk_all_zero("reset");
        RSTN = 1'b1;
        repeat (BIT) cyc();
        chk_all_zero("post_reset");

        // Single byte, consumer not ready: head must be held stable
        send_frame(8'hA5, 1'b1);
        chk_head("a5");
        chk_flags("a5");
        repeat (5) cyc();
        chk_head("a5_hold");
        drain("a5");

        // Glitch shorter than half a bit is rejected
        RXD = 1'b0;
        repeat (6) cyc();
        RXD = 1'b1;
        repeat (2 * BIT) cyc();
        chk_head("false_start");
        chk_flags("false_start");

        // Framing error, then the receiver recovers
        send_frame(8'h3C, 1'b0);
        chk_head("ferr");
        chk_flags("ferr");
        send_frame(8'h55, 1'b1);
        chk_head("after_ferr");
        chk_flags("after_ferr");
        drain("after_ferr");
        clear_flags();
        chk_flags("clr1");

        // Overrun: 17 bytes into a 16-deep FIFO
        for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1);
        chk("ovr.count", fifo_count, 16);
        chk("ovr.data", rx_data, 8'h00);
        chk_flags("ovr");
        drain("ovr");
        clear_flags();
        chk_flags("clr2");

        // End-of-test character
        send_frame(8'h04, 1'b1);
        chk_head("eot");
        chk_flags("eot");
        clear_flags();
        chk_flags("eot_clr");
        chk_head("eot_clr");
        drain("eot");

        // Reset in the middle of a frame, with data and a flag pending
        send_frame(8'h7E, 1'b1);
        send_frame(8'h11, 1'b0);
        chk_head("pre_rst");
        chk_flags("pre_rst");
        f0 = 8'hF0;
        RXD = 1'b0;
        repeat (BIT) cyc();
        for (int i = 0; i < 4; i++) begin
            RXD = f0[i];
            repeat (BIT) cyc();
        end
        RSTN = 1'b0;
        RXD = 1'b1;
        mq.delete();
        m_fe = 1'b0;
        m_ov = 1'b0;
        m_eot = 1'b0;
        repeat (3) cyc();
        chk_all_zero("mid_rst");
        RSTN = 1'b1;
        repeat (BIT) cyc();
        send_frame(8'h81, 1'b1);
        chk_head("after_rst");
        chk_flags("after_rst");
        drain("after_rst");

        // Randomized streams with occasional bad stop bits
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 19);
            for (int k = 0; k < n; k++) begin
                b  = 8'($urandom);
                ok = ($urandom_range(0, 6) != 0);
                send_frame(b, ok);
            end
            chk_head("rnd");
            chk_flags("rnd");
            drain("rnd");
            clear_flags();
            chk_flags("rnd_clr");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
